// File: rtl/conv_seq_ctrl_pkg.sv
// Shared constants for the convolution sequencer: instruction-word bit map,
// FSM state encoding, fixed phase lengths and tile geometry.
package conv_seq_ctrl_pkg;

  localparam int unsigned InstW = 64;
  localparam int unsigned AddrW = 11;

  localparam int unsigned BitDebug   = 63;
  localparam int unsigned BitRenPmem = 35;
  localparam int unsigned BitSfuPass = 34;
  localparam int unsigned BitAcc     = 33;
  localparam int unsigned BitCenPmem = 32;
  localparam int unsigned BitWenPmem = 31;
  localparam int unsigned BitApmemLo = 20;
  localparam int unsigned BitCenXmem = 19;
  localparam int unsigned BitWenXmem = 18;
  localparam int unsigned BitAxmemLo = 7;
  localparam int unsigned BitOfifoRd = 6;
  localparam int unsigned BitIfifoWr = 5;
  localparam int unsigned BitIfifoRd = 4;
  localparam int unsigned BitL0Rd    = 3;
  localparam int unsigned BitL0Wr    = 2;
  localparam int unsigned BitExecute = 1;
  localparam int unsigned BitLoad    = 0;

  localparam int unsigned WeightBase = 1024;
  localparam int unsigned ClrCycles  = 12;
  localparam int unsigned GapCycles  = 10;

  // Input tile, kernel and output-plane edge lengths
  localparam int unsigned TileW = 6;
  localparam int unsigned KerW  = 3;
  localparam int unsigned OutW  = 4;

  typedef enum logic [3:0] {
    StIdle,
    StClr,
    StWrl0,
    StLoad,
    StGap,
    StExec,
    StDrain,
    StNext,
    StReadout,
    StDone
  } state_e;

  function automatic logic [InstW-1:0] idle_word();
    logic [InstW-1:0] w;
    w             = '0;
    w[BitCenXmem] = 1'b1;
    w[BitWenXmem] = 1'b1;
    w[BitCenPmem] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// Control/handshake bundle between the sequencer and the core it drives.
interface conv_seq_ctrl_if;
  logic        start;
  logic        ofifo_valid;
  logic [63:0] inst;
  logic        array_clr;
  logic        busy;
  logic        out_valid;
  logic [3:0]  out_idx;
  logic        done;
  logic        err_timeout;

  modport slave (
    input  start, ofifo_valid,
    output inst, array_clr, busy, out_valid, out_idx, done, err_timeout
  );

  modport master (
    output start, ofifo_valid,
    input  inst, array_clr, busy, out_valid, out_idx, done, err_timeout
  );
endinterface

// File: rtl/conv_seq_ctrl_onij_map.sv
// Maps an OFIFO row index and kernel tap to the output pixel it contributes to.
module conv_seq_ctrl_onij_map
  import conv_seq_ctrl_pkg::*;
#(
  parameter int unsigned RW = 6,
  parameter int unsigned KW = 4
) (
  input  logic [RW-1:0] r_i,
  input  logic [KW-1:0] kij_i,
  output logic [3:0]    onij_o,
  output logic          valid_o
);

  int dx;
  int dy;

  always_comb begin
    dx      = int'(r_i % RW'(TileW)) - int'(kij_i % KW'(KerW));
    dy      = int'(r_i / RW'(TileW)) - int'(kij_i / KW'(KerW));
    valid_o = (dx >= 0) && (dx < int'(OutW)) && (dy >= 0) && (dy < int'(OutW));
    onij_o  = valid_o ? 4'(dx + int'(OutW) * dy) : 4'd0;
  end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequencer issuing core instruction words for a full multi-tap convolution:
// per tap clear, weight load, execute and drain with PSUM accumulation, then readout.
module conv_seq_ctrl
  import conv_seq_ctrl_pkg::*;
#(
  parameter int unsigned col       = 8,
  parameter int unsigned row       = 8,
  parameter int unsigned len_nij   = 36,
  parameter int unsigned len_kij   = 9,
  parameter int unsigned len_onij  = 16,
  parameter int unsigned drain_max = 64
) (
  input logic          clk,
  input logic          reset,
  conv_seq_ctrl_if.slave bus
);

  localparam int unsigned CntW = 16;
  localparam int unsigned RW   = $clog2(len_nij + 1);
  localparam int unsigned KW   = (len_kij > 1) ? $clog2(len_kij) : 1;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [KW-1:0]     kij_q, kij_d;
  logic [RW-1:0]     r_q, r_d;
  logic              err_q, err_d;
  logic [InstW-1:0]  inst_q, inst_d;
  logic              clr_q, clr_d;
  logic              busy_q, busy_d;
  logic              ov_q, ov_d;
  logic [3:0]        idx_q, idx_d;
  logic              done_q, done_d;

  logic              rd_fire;
  logic              map_valid;
  logic [3:0]        onij;
  logic [InstW-1:0]  inst_o;

  conv_seq_ctrl_onij_map #(
    .RW(RW),
    .KW(KW)
  ) u_onij_map (
    .r_i    (r_q),
    .kij_i  (kij_q),
    .onij_o (onij),
    .valid_o(map_valid)
  );

  // OFIFO pops are combinational so a row is consumed in the cycle it shows up
  assign rd_fire = ((state_q == StExec) || (state_q == StDrain)) && bus.ofifo_valid &&
                   (r_q < RW'(len_nij));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    kij_d   = kij_q;
    r_d     = rd_fire ? r_q + RW'(1) : r_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (bus.start) begin
          state_d = StClr;
          kij_d   = '0;
          err_d   = 1'b0;
        end
      end
      StClr: begin
        r_d = '0;
        if (cnt_q == CntW'(ClrCycles - 1)) begin
          state_d = StWrl0;
          cnt_d   = '0;
        end
      end
      StWrl0: begin
        if (cnt_q == CntW'(col)) begin
          state_d = StLoad;
          cnt_d   = '0;
        end
      end
      StLoad: begin
        if (cnt_q == CntW'(col + row)) begin
          state_d = StGap;
          cnt_d   = '0;
        end
      end
      StGap: begin
        if (cnt_q == CntW'(GapCycles - 1)) begin
          state_d = StExec;
          cnt_d   = '0;
        end
      end
      StExec: begin
        if (cnt_q == CntW'(len_nij)) begin
          state_d = StDrain;
          cnt_d   = '0;
        end
      end
      StDrain: begin
        if (r_q == RW'(len_nij)) begin
          state_d = StNext;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(drain_max - 1)) begin
          state_d = StNext;
          cnt_d   = '0;
          err_d   = 1'b1;
        end
      end
      StNext: begin
        cnt_d = '0;
        if (kij_q == KW'(len_kij - 1)) begin
          state_d = StReadout;
        end else begin
          state_d = StClr;
          kij_d   = kij_q + KW'(1);
        end
      end
      StReadout: begin
        if (cnt_q == CntW'(len_onij)) begin
          state_d = StDone;
          cnt_d   = '0;
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from the next state so the registered copy lines up with state_q
  always_comb begin
    inst_d = idle_word();
    clr_d  = 1'b0;
    busy_d = (state_d != StIdle);
    ov_d   = 1'b0;
    idx_d  = '0;
    done_d = 1'b0;
    case (state_d)
      StClr: clr_d = (cnt_d < CntW'(ClrCycles - 1));
      StWrl0: begin
        if (cnt_d < CntW'(col)) begin
          inst_d[BitCenXmem] = 1'b0;
          inst_d[BitAxmemLo +: AddrW] =
            AddrW'(WeightBase + 32'(kij_d) * col + 32'(cnt_d));
        end
        if (cnt_d != '0) inst_d[BitL0Wr] = 1'b1;
      end
      StLoad: begin
        inst_d[BitL0Rd] = 1'b1;
        inst_d[BitLoad] = (cnt_d != '0);
      end
      StExec: begin
        if (cnt_d < CntW'(len_nij)) begin
          inst_d[BitCenXmem]          = 1'b0;
          inst_d[BitAxmemLo +: AddrW] = AddrW'(cnt_d);
          inst_d[BitL0Wr]             = 1'b1;
        end
        if (cnt_d != '0) begin
          inst_d[BitL0Rd]    = 1'b1;
          inst_d[BitExecute] = 1'b1;
        end
      end
      StReadout: begin
        if (cnt_d < CntW'(len_onij)) begin
          inst_d[BitCenPmem]          = 1'b0;
          inst_d[BitApmemLo +: AddrW] = AddrW'(cnt_d);
        end
        // PSUM SRAM returns data one cycle after the address
        if (cnt_d != '0) begin
          ov_d  = 1'b1;
          idx_d = 4'(cnt_d - CntW'(1));
        end
      end
      StDone:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      kij_q   <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
      inst_q  <= idle_word();
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
      ov_q    <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kij_q   <= kij_d;
      r_q     <= r_d;
      err_q   <= err_d;
      inst_q  <= inst_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
      ov_q    <= ov_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    inst_o = inst_q;
    if (rd_fire) begin
      inst_o[BitOfifoRd] = 1'b1;
      if (map_valid) begin
        inst_o[BitCenPmem]          = 1'b0;
        inst_o[BitWenPmem]          = 1'b1;
        inst_o[BitApmemLo +: AddrW] = AddrW'(onij);
        inst_o[BitSfuPass]          = (kij_q == '0);
        inst_o[BitAcc]              = (kij_q != '0);
      end
    end
  end

  assign bus.inst        = inst_o;
  assign bus.array_clr   = clr_q;
  assign bus.busy        = busy_q;
  assign bus.out_valid   = ov_q;
  assign bus.out_idx     = idx_q;
  assign bus.done        = done_q;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Randomised bench for conv_seq_ctrl: a phase-by-phase model of the instruction
// stream is compared against the DUT every cycle.
module tb_conv_seq_ctrl;

  localparam int Col = 8, Row = 8, Nij = 36, Kij = 9, Onij = 16, DrainMax = 64;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  conv_seq_ctrl_if bus ();

  conv_seq_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int tab[Kij][Nij];
  int cur_kij    = -1;
  int starve_kij = -1;
  int exec_seen  = 0;
  int r_m        = 0;
  int dut_wr0    = 0;
  int ov_cnt     = 0;
  int done_cnt   = 0;
  bit err_m      = 1'b0;
  bit noise      = 1'b0;
  bit noise_en   = 1'b0;
  bit start_req  = 1'b0;
  bit aborted;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs just after the edge, then settle to the falling edge
  task automatic step();
    @(posedge clk);
    #1;
    bus.start       = noise ? ($urandom_range(0, 3) == 0) : start_req;
    bus.ofifo_valid = (cur_kij != starve_kij) && (exec_seen > Row) &&
                      ($urandom_range(0, 3) != 0);
    @(negedge clk);
    if (bus.inst[1])   exec_seen++;
    if (bus.array_clr) exec_seen = 0;
    if (bus.out_valid) ov_cnt++;
    if (bus.done)      done_cnt++;
  endtask

  function automatic logic [63:0] idle_w();
    return 64'h0000_0001_000C_0000;
  endfunction

  task automatic expect_out(input string tag, input logic [63:0] w, input bit clr,
                            input bit bsy, input bit ov, input int idx, input bit dn);
    chk({tag, " inst"},      bus.inst,              w);
    chk({tag, " array_clr"}, 64'(bus.array_clr),    64'(clr));
    chk({tag, " busy"},      64'(bus.busy),         64'(bsy));
    chk({tag, " out_valid"}, 64'(bus.out_valid),    64'(ov));
    chk({tag, " out_idx"},   64'(bus.out_idx),      64'(idx));
    chk({tag, " done"},      64'(bus.done),         64'(dn));
    chk({tag, " err"},       64'(bus.err_timeout),  64'(err_m));
  endtask

  // Apply the OFIFO read (if any) this cycle to the expected word and bump r
  task automatic read_overlay(inout logic [63:0] w, input int k);
    if (bus.ofifo_valid && r_m < Nij) begin
      w[6] = 1'b1;
      if (tab[k][r_m] >= 0) begin
        w[32]    = 1'b0;
        w[31]    = 1'b1;
        w[30:20] = 11'(tab[k][r_m]);
        w[34]    = (k == 0);
        w[33]    = (k != 0);
        if (k == 0 && bus.inst[6] && !bus.inst[32]) dut_wr0++;
      end
      r_m++;
    end
  endtask

  task automatic run_conv(input int abort_kij, output bit was_aborted);
    logic [63:0] w;
    bit          stop;
    was_aborted = 1'b0;
    start_req   = 1'b1;
    step();
    expect_out("idle-start", idle_w(), 0, 0, 0, 0, 0);
    start_req = 1'b0;
    err_m     = 1'b0;
    noise     = noise_en;
    for (int k = 0; k < Kij; k++) begin
      cur_kij = k;
      for (int c = 0; c < 12; c++) begin
        step();
        expect_out($sformatf("clr k%0d c%0d", k, c), idle_w(), c < 11, 1, 0, 0, 0);
      end
      for (int c = 0; c <= Col; c++) begin
        w = idle_w();
        if (c < Col) begin
          w[19]   = 1'b0;
          w[17:7] = 11'(1024 + k * Col + c);
        end
        if (c >= 1) w[2] = 1'b1;
        step();
        expect_out($sformatf("wrl0 k%0d c%0d", k, c), w, 0, 1, 0, 0, 0);
      end
      for (int c = 0; c <= Col + Row; c++) begin
        w    = idle_w();
        w[3] = 1'b1;
        w[0] = (c >= 1);
        step();
        expect_out($sformatf("load k%0d c%0d", k, c), w, 0, 1, 0, 0, 0);
      end
      for (int c = 0; c < 10; c++) begin
        step();
        expect_out($sformatf("gap k%0d c%0d", k, c), idle_w(), 0, 1, 0, 0, 0);
      end
      r_m = 0;
      for (int c = 0; c <= Nij; c++) begin
        w = idle_w();
        if (c < Nij) begin
          w[19]   = 1'b0;
          w[17:7] = 11'(c);
          w[2]    = 1'b1;
        end
        if (c >= 1) begin
          w[3] = 1'b1;
          w[1] = 1'b1;
        end
        step();
        read_overlay(w, k);
        expect_out($sformatf("exec k%0d c%0d", k, c), w, 0, 1, 0, 0, 0);
        if (k == abort_kij && c == 10) begin
          #2;
          reset = 1'b0;
          #1;
          chk("async reset inst", bus.inst, 64'h0000_0001_000C_0000);
          chk("async reset busy", 64'(bus.busy), 64'd0);
          chk("async reset array_clr", 64'(bus.array_clr), 64'd0);
          chk("async reset out_valid", 64'(bus.out_valid), 64'd0);
          was_aborted = 1'b1;
          noise       = 1'b0;
          return;
        end
      end
      stop = 1'b0;
      for (int d = 0; d < DrainMax && !stop; d++) begin
        int rr;
        rr = r_m;
        w  = idle_w();
        step();
        read_overlay(w, k);
        expect_out($sformatf("drain k%0d d%0d", k, d), w, 0, 1, 0, 0, 0);
        if (rr == Nij) stop = 1'b1;
        else if (d == DrainMax - 1) err_m = 1'b1;
      end
      step();
      expect_out($sformatf("next k%0d", k), idle_w(), 0, 1, 0, 0, 0);
    end
    for (int c = 0; c <= Onij; c++) begin
      w = idle_w();
      if (c < Onij) begin
        w[32]    = 1'b0;
        w[30:20] = 11'(c);
      end
      step();
      expect_out($sformatf("readout c%0d", c), w, 0, 1, c >= 1, (c >= 1) ? c - 1 : 0, 0);
    end
    step();
    expect_out("done", idle_w(), 0, 1, 0, 0, 1);
    noise = 1'b0;
    step();
    expect_out("idle-after", idle_w(), 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    bus.start       = 1'b0;
    bus.ofifo_valid = 1'b0;

    // Output-pixel table from output position plus kernel offset
    for (int k = 0; k < Kij; k++)
      for (int r = 0; r < Nij; r++) tab[k][r] = -1;
    for (int k = 0; k < Kij; k++)
      for (int oy = 0; oy < 4; oy++)
        for (int ox = 0; ox < 4; ox++)
          tab[k][(oy + k / 3) * 6 + ox + k % 3] = oy * 4 + ox;
    chk("model k4 r7 onij", 64'(tab[4][7]), 64'd0);
    chk("model k4 r0 discard", 64'(tab[4][0] < 0), 64'd1);
    chk("model k8 r35 onij", 64'(tab[8][35]), 64'd15);
    n = 0;
    for (int r = 0; r < Nij; r++) if (tab[0][r] >= 0) n++;
    chk("model k0 write count", 64'(n), 64'd16);

    #12;
    chk("reset inst", bus.inst, 64'h0000_0001_000C_0000);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset array_clr", 64'(bus.array_clr), 64'd0);
    chk("reset err", 64'(bus.err_timeout), 64'd0);
    chk("reset out_idx", 64'(bus.out_idx), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    expect_out("idle", idle_w(), 0, 0, 0, 0, 0);

    // Clean run
    dut_wr0  = 0;
    ov_cnt   = 0;
    done_cnt = 0;
    run_conv(-1, aborted);
    chk("kij0 pmem writes", 64'(dut_wr0), 64'd16);
    chk("out_valid count", 64'(ov_cnt), 64'd16);
    chk("done pulses", 64'(done_cnt), 64'd1);

    // Start pulses while busy must be ignored
    noise_en = 1'b1;
    run_conv(-1, aborted);
    noise_en = 1'b0;

    // Starved drain on kij=2 times out but the sequence carries on
    starve_kij = 2;
    run_conv(-1, aborted);
    starve_kij = -1;
    chk("sticky err in idle", 64'(bus.err_timeout), 64'd1);

    // Reset mid-EXEC of kij=3, then a fresh run from kij=0
    run_conv(3, aborted);
    chk("abort taken", 64'(aborted), 64'd1);
    err_m   = 1'b0;
    cur_kij = -1;
    repeat (2) @(negedge clk);
    exec_seen = 0;
    reset     = 1'b1;
    step();
    expect_out("idle post-reset", idle_w(), 0, 0, 0, 0, 0);
    run_conv(-1, aborted);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_seq_ctrl.md
CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 Parameter col, default 8: PE array columns; weight rows per kij.
REQ-002 Parameter row, default 8: PE array rows.
REQ-003 Parameter len_nij, default 36: input pixels per tile (6x6).
REQ-004 Parameter len_kij, default 9: kernel taps (3x3).
REQ-005 Parameter len_onij, default 16: output pixels (4x4).
REQ-006 Parameter drain_max, default 64: DRAIN timeout in cycles.
REQ-007 clk  in  1  sole clock; all state changes on its rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  one-cycle request to run a full 9-tap convolution; sampled only in IDLE.
REQ-010 ofifo_valid  in  1  core OFIFO holds a complete row.
REQ-011 inst  out  64  core instruction word: [63] debug, [35] REN_pmem, [34] sfu_passthrough, [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load; unlisted bits 0.
REQ-012 array_clr  out  1  active-high reset to core datapath (PEs/L0/OFIFO); PSUM SRAM unaffected.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 out_valid  out  1  sfp_out holds final output for out_idx this cycle.
REQ-015 out_idx  out  4  output pixel index for out_valid.
REQ-016 done  out  1  one-cycle pulse at end of readout.
REQ-017 err_timeout  out  1  sticky; set on DRAIN timeout, cleared by next accepted start.

Function
REQ-018 Idle word SHALL be: CEN_xmem=1, WEN_xmem=1, CEN_pmem=1, WEN_pmem=0, all other fields 0; emitted in every cycle/field not driven below.
REQ-019 FSM states SHALL be IDLE, CLR, WRL0, LOAD, GAP, EXEC, DRAIN, NEXT, READOUT, DONE; a kij counter 0..len_kij-1 is cleared on start.
REQ-020 IDLE->CLR on start; start while busy is ignored.
REQ-021 CLR: 12 cycles, array_clr=1 for the first 11, 0 on the 12th; ->WRL0.
REQ-022 WRL0: col+1 cycles; cycles c=0..col-1 CEN_xmem=0, WEN_xmem=1, A_xmem=1024+kij*col+c; cycles 1..col l0_wr=1; ->LOAD.
REQ-023 LOAD: col+row+1 cycles; l0_rd=1 throughout, load=1 on cycles 1..col+row; ->GAP.
REQ-024 GAP: 10 idle cycles; ->EXEC.
REQ-025 EXEC: len_nij+1 cycles; cycles c=0..len_nij-1 CEN_xmem=0, A_xmem=c, l0_wr=1; cycles 1..len_nij l0_rd=1, execute=1; ->DRAIN.
REQ-026 In EXEC and DRAIN, a row counter r (0..len_nij) SHALL track OFIFO reads; when ofifo_valid=1 and r<len_nij, ofifo_rd=1 in the same cycle (combinational), r increments at the edge.
REQ-027 On each such read, onij=(r%6-kij%3)+4*(r/6-kij/3) when both terms lie in 0..3: CEN_pmem=0, WEN_pmem=1, A_pmem=onij, sfu_passthrough=(kij==0), acc=(kij!=0); otherwise CEN_pmem=1 (row discarded).
REQ-028 DRAIN->NEXT when r==len_nij; after drain_max cycles in DRAIN with r<len_nij, set err_timeout and go ->NEXT.
REQ-029 NEXT (1 cycle): if kij==len_kij-1 ->READOUT, else kij++ and ->CLR.
REQ-030 READOUT: len_onij cycles i=0..15, CEN_pmem=0, WEN_pmem=0, A_pmem=i; out_valid=1, out_idx=i one cycle later (SRAM latency 1); ->DONE after last out_valid.
REQ-031 DONE: done=1 for one cycle; ->IDLE.
REQ-032 All outputs except ofifo_rd and its REQ-027 companions SHALL be registered.

Reset
REQ-033 reset low SHALL immediately force IDLE, kij=0, r=0, idle word, array_clr=0, busy=0, out_valid=0, out_idx=0, done=0, err_timeout=0, including mid-operation.

Structure
REQ-034 Shared package: inst bit-position constants, state encoding, weight base address 1024, GAP/CLR lengths.
REQ-035 One sub-module, onij_map (combinational r,kij -> onij,valid); the FSM and counters stay in conv_seq_ctrl.

Verification
REQ-036 start with ofifo_valid tied to a model of core latency -> 9 CLR..DRAIN passes, 16 out_valid with out_idx 0..15, done pulse, err_timeout=0.
REQ-037 kij=4, r=7 read -> A_pmem=0, CEN_pmem=0, acc=1; r=0 -> CEN_pmem=1.
REQ-038 kij=0 -> every valid write has sfu_passthrough=1, acc=0; 16 of 36 reads write.
REQ-039 ofifo_valid held 0 in DRAIN -> err_timeout=1 after 64 cycles, FSM advances to next kij.
REQ-040 reset low mid-EXEC of kij=3 -> idle word and busy=0 asynchronously; next start restarts at kij=0.
REQ-041 start pulsed during LOAD -> no effect on sequence or kij.
